// File: rtl/score_counter.sv
// Game scorekeeper: counts held-button frames into points, freezes the score on
// collision and tracks the session high score. Updates land on the blanking tick.
module score_counter #(
  parameter int FRAMES_PER_POINT = 8,
  parameter int SCORE_MAX        = 255,
  parameter int TICK_VPOS        = 480
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_vpos,
  input  logic [9:0] i_hpos,
  input  logic       i_move,
  input  logic       i_collision,
  input  logic       i_start,
  output logic [7:0] o_score,
  output logic [7:0] o_high_score,
  output logic       o_game_over,
  output logic       o_playing
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [7:0] FCNT_LAST  = 8'(FRAMES_PER_POINT - 1);
  localparam logic [8:0] SCORE_MAX9 = 9'(SCORE_MAX);

  state_t     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [7:0] high_q, high_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       game_over_q, game_over_d;
  logic       playing_q, playing_d;

  logic       tick;
  logic       move_s;
  logic [8:0] score_inc;

  assign tick      = (i_vpos == 10'(TICK_VPOS)) && (i_hpos == 10'd0);
  assign move_s    = sync2_q;
  // 9-bit sum so a 255 ceiling cannot wrap back to zero
  assign score_inc = {1'b0, score_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    fcnt_d  = fcnt_q;
    sync1_d = i_move;
    sync2_d = sync1_q;
    case (state_q)
      IDLE: begin
        score_d = 8'd0;
        fcnt_d  = 8'd0;
        if (i_start) state_d = PLAY;
      end
      PLAY: begin
        if (i_collision) begin
          state_d = OVER;
          if (score_q > high_q) high_d = score_q;
        end else if (tick) begin
          if (move_s) begin
            if (fcnt_q == FCNT_LAST) begin
              fcnt_d  = 8'd0;
              score_d = (score_inc > SCORE_MAX9) ? SCORE_MAX9[7:0] : score_inc[7:0];
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end else begin
            fcnt_d = 8'd0;
          end
        end
      end
      OVER: begin
        if (i_start) begin
          state_d = PLAY;
          score_d = 8'd0;
          fcnt_d  = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    playing_d   = (state_d == PLAY);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      score_q     <= 8'd0;
      high_q      <= 8'd0;
      fcnt_q      <= 8'd0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      game_over_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      high_q      <= high_d;
      fcnt_q      <= fcnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      game_over_q <= game_over_d;
      playing_q   <= playing_d;
    end
  end

  assign o_score      = score_q;
  assign o_high_score = high_q;
  assign o_game_over  = game_over_q;
  assign o_playing    = playing_q;

endmodule
